// File: rtl/nand_bist_pkg.sv
// Shared types and constants for the NAND cell self-test controller.
package nand_bist_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NUM_PAT = 4;

  // Bit i is the expected y when the gate sees a=i[1], b=i[0].
  localparam logic [NUM_PAT-1:0] EXP_Y = 4'b0111;

  function automatic logic exp_y(input logic [1:0] idx);
    return EXP_Y[idx];
  endfunction

endpackage

// File: rtl/nand_bist_checker.sv
// Compares sampled gate output against the NAND truth table and accumulates
// a saturating mismatch count plus a sticky per-pattern fail vector.
module nand_bist_checker
  import nand_bist_pkg::*;
#(
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             sample,
  input  logic [1:0]       idx,
  input  logic             dut_y,
  output logic [ERR_W-1:0] err_count,
  output logic [NUM_PAT-1:0] fail_vec
);

  logic             mismatch;
  logic [ERR_W-1:0] err_count_reg;
  logic [NUM_PAT-1:0] fail_vec_reg;

  assign mismatch = sample && (dut_y != exp_y(idx));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count_reg <= '0;
    end else if (clear) begin
      err_count_reg <= '0;
    end else if (mismatch && (err_count_reg != {ERR_W{1'b1}})) begin
      err_count_reg <= err_count_reg + 1'b1;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_PAT; gi++) begin : g_fail
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          fail_vec_reg[gi] <= 1'b0;
        end else if (clear) begin
          fail_vec_reg[gi] <= 1'b0;
        end else if (mismatch && (idx == 2'(gi))) begin
          fail_vec_reg[gi] <= 1'b1;
        end
      end
    end
  endgenerate

  assign err_count = err_count_reg;
  assign fail_vec  = fail_vec_reg;

endmodule

// File: rtl/nand_bist.sv
// Self-test sequencer for a two-input NAND cell: walks the four input
// patterns, holding each for SETTLE_CYCLES, and samples y at window end.
module nand_bist
  import nand_bist_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int LOOPS         = 1,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             dut_y,
  output logic             pat_a,
  output logic             pat_b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [NUM_PAT-1:0] fail_vec
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int LW = $clog2(LOOPS + 1);

  state_t          state_reg, state_next;
  logic [SW-1:0]   settle_cnt_reg, settle_cnt_next;
  logic [LW-1:0]   loop_cnt_reg, loop_cnt_next;
  logic [1:0]      idx_reg, idx_next;

  logic run_start;
  logic last_settle;
  logic last_pat;
  logic last_loop;
  logic sample;

  // Abort takes priority over start, and start is ignored while running.
  assign run_start   = (state_reg != RUN) && start && !abort;
  assign last_settle = (settle_cnt_reg == SW'(SETTLE_CYCLES - 1));
  assign last_pat    = (idx_reg == 2'(NUM_PAT - 1));
  assign last_loop   = (loop_cnt_reg == LW'(LOOPS - 1));
  assign sample      = (state_reg == RUN) && !abort && last_settle;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      settle_cnt_reg <= '0;
      loop_cnt_reg   <= '0;
      idx_reg        <= '0;
    end else begin
      state_reg      <= state_next;
      settle_cnt_reg <= settle_cnt_next;
      loop_cnt_reg   <= loop_cnt_next;
      idx_reg        <= idx_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE, DONE: if (run_start) state_next = RUN;
      RUN: begin
        if (abort) begin
          state_next = IDLE;
        end else if (sample && last_pat && last_loop) begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Counters park at zero whenever the next state is not RUN, which also
  // returns the pattern outputs to 00 outside a run.
  always_comb begin
    settle_cnt_next = '0;
    loop_cnt_next   = '0;
    idx_next        = '0;
    if (state_reg == RUN && state_next == RUN) begin
      if (sample) begin
        idx_next      = idx_reg + 2'd1;
        loop_cnt_next = last_pat ? loop_cnt_reg + 1'b1 : loop_cnt_reg;
      end else begin
        settle_cnt_next = settle_cnt_reg + 1'b1;
        loop_cnt_next   = loop_cnt_reg;
        idx_next        = idx_reg;
      end
    end
  end

  always_comb begin
    busy  = (state_reg == RUN);
    done  = (state_reg == DONE);
    pat_a = idx_reg[1];
    pat_b = idx_reg[0];
  end

  nand_bist_checker #(
    .ERR_W (ERR_W)
  ) u_checker (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (run_start),
    .sample    (sample),
    .idx       (idx_reg),
    .dut_y     (dut_y),
    .err_count (err_count),
    .fail_vec  (fail_vec)
  );

  assign pass = done && (err_count == '0);

endmodule

// File: tb/tb_nand_bist.sv
// Directed bench: three controller instances (default, LOOPS=3,
// ERR_W=2/LOOPS=2) each driving a gate model selected by gate_mode.
`timescale 1ns/1ps
module tb_nand_bist;

  logic clk = 1'b0;
  logic rst_n, start, abort;
  int   gate_mode; // 0 = NAND, 1 = AND, 2 = stuck-at-1

  logic       pa0, pb0, y0, busy0, done0, pass0;
  logic [7:0] err0;
  logic [3:0] fail0;
  logic       pa1, pb1, y1, busy1, done1, pass1;
  logic [7:0] err1;
  logic [3:0] fail1;
  logic       pa2, pb2, y2, busy2, done2, pass2;
  logic [1:0] err2;
  logic [3:0] fail2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign y0 = (gate_mode == 0) ? ~(pa0 & pb0) : (gate_mode == 1) ? (pa0 & pb0) : 1'b1;
  assign y1 = (gate_mode == 0) ? ~(pa1 & pb1) : (gate_mode == 1) ? (pa1 & pb1) : 1'b1;
  assign y2 = (gate_mode == 0) ? ~(pa2 & pb2) : (gate_mode == 1) ? (pa2 & pb2) : 1'b1;

  nand_bist u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .dut_y(y0),
    .pat_a(pa0), .pat_b(pb0), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .fail_vec(fail0)
  );

  nand_bist #(.LOOPS(3)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .dut_y(y1),
    .pat_a(pa1), .pat_b(pb1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .fail_vec(fail1)
  );

  nand_bist #(.ERR_W(2), .LOOPS(2)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .dut_y(y2),
    .pat_a(pa2), .pat_b(pb2), .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2), .fail_vec(fail2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Leaves the bench 1ns after the edge that sampled start.
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_all_done();
    int n = 0;
    while (!(done0 && done1 && done2) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("wait_done", {31'd0, done0 & done1 & done2}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; gate_mode = 0;
    repeat (3) @(posedge clk);
    #1;
    $display("run reset");
    check("rst_pat",  {30'd0, pa0, pb0}, 32'd0);
    check("rst_busy", {31'd0, busy0}, 32'd0);
    check("rst_done", {31'd0, done0}, 32'd0);
    check("rst_pass", {31'd0, pass0}, 32'd0);
    check("rst_err",  {24'd0, err0}, 32'd0);
    check("rst_fail", {28'd0, fail0}, 32'd0);
    @(negedge clk) rst_n = 1'b1;

    $display("run start+abort in idle");
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; abort = 1'b0;
    check("sa_busy", {31'd0, busy0}, 32'd0);
    check("sa_done", {31'd0, done0}, 32'd0);

    $display("run good nand");
    pulse_start();
    for (int k = 0; k < 8; k++) begin
      check($sformatf("seq_pat%0d", k), {30'd0, pa0, pb0}, 32'(k / 2));
      check($sformatf("seq_busy%0d", k), {31'd0, busy0}, 32'd1);
      @(posedge clk);
      #1;
    end
    check("good_busy", {31'd0, busy0}, 32'd0);
    check("good_done", {31'd0, done0}, 32'd1);
    check("good_pass", {31'd0, pass0}, 32'd1);
    check("good_err",  {24'd0, err0}, 32'd0);
    check("good_fail", {28'd0, fail0}, 32'd0);
    check("good_pat",  {30'd0, pa0, pb0}, 32'd0);
    wait_all_done();
    check("good_pass1", {31'd0, pass1}, 32'd1);

    $display("run and gate");
    gate_mode = 1;
    pulse_start();
    check("and_done_drop", {31'd0, done0}, 32'd0);
    wait_all_done();
    check("and_err0",  {24'd0, err0}, 32'd4);
    check("and_fail0", {28'd0, fail0}, 32'hF);
    check("and_pass0", {31'd0, pass0}, 32'd0);
    check("and_done0", {31'd0, done0}, 32'd1);
    check("and_err1",  {24'd0, err1}, 32'd12);
    check("sat_err2",  {30'd0, err2}, 32'd3);
    check("sat_fail2", {28'd0, fail2}, 32'hF);

    $display("run stuck-at-1");
    gate_mode = 2;
    pulse_start();
    check("stk_clr_err",  {24'd0, err0}, 32'd0);
    check("stk_clr_fail", {28'd0, fail0}, 32'd0);
    check("stk_clr_done", {31'd0, done0}, 32'd0);
    wait_all_done();
    check("stk_err1",  {24'd0, err1}, 32'd3);
    check("stk_fail1", {28'd0, fail1}, 32'h8);
    check("stk_pass1", {31'd0, pass1}, 32'd0);
    check("stk_err0",  {24'd0, err0}, 32'd1);

    $display("run abort");
    gate_mode = 1;
    pulse_start();
    repeat (2) begin @(posedge clk); #1; end
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    check("ab_busy", {31'd0, busy0}, 32'd0);
    check("ab_pat",  {30'd0, pa0, pb0}, 32'd0);
    check("ab_done", {31'd0, done0}, 32'd0);
    check("ab_err",  {24'd0, err0}, 32'd1);
    check("ab_fail", {28'd0, fail0}, 32'h1);
    pulse_start();
    check("ab_re_err",  {24'd0, err0}, 32'd0);
    check("ab_re_fail", {28'd0, fail0}, 32'd0);
    check("ab_re_busy", {31'd0, busy0}, 32'd1);
    wait_all_done();
    check("ab_re_final", {24'd0, err0}, 32'd4);

    $display("run start while busy");
    gate_mode = 0;
    pulse_start();
    repeat (2) begin @(posedge clk); #1; end
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    check("sb_busy7", {31'd0, busy0}, 32'd1);
    check("sb_pat7",  {30'd0, pa0, pb0}, 32'd3);
    @(posedge clk);
    #1;
    check("sb_done8", {31'd0, done0}, 32'd1);
    check("sb_busy8", {31'd0, busy0}, 32'd0);
    wait_all_done();

    $display("run reset mid-run");
    gate_mode = 1;
    pulse_start();
    repeat (3) begin @(posedge clk); #1; end
    check("mr_err_pre", {24'd0, err0}, 32'd1);
    @(negedge clk) rst_n = 1'b0;
    #1;
    check("mr_busy", {31'd0, busy0}, 32'd0);
    check("mr_pat",  {30'd0, pa0, pb0}, 32'd0);
    check("mr_err",  {24'd0, err0}, 32'd0);
    check("mr_fail", {28'd0, fail0}, 32'd0);
    check("mr_done", {31'd0, done0}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    check("mr_no_resume", {31'd0, busy0}, 32'd0);
    check("mr_no_done",   {31'd0, done0}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
